// File: rtl/ternary_pkg.sv
// ternary_pkg: ternary weight codes, engine state encoding and width helpers.
package ternary_pkg;

   localparam logic [1:0] T_ZERO = 2'b00;
   localparam logic [1:0] T_POS  = 2'b01;
   localparam logic [1:0] T_NEG  = 2'b11;
   localparam logic [1:0] T_RSVD = 2'b10;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   // Signed weight value of a 2-bit code; the reserved code reads as zero.
   function automatic logic signed [1:0] decode_wgt(input logic [1:0] code);
      case (code)
         T_POS:          return 2'sb01;
         T_NEG:          return 2'sb11;
         T_ZERO, T_RSVD: return 2'sb00;
         default:        return 2'sb00;
      endcase
   endfunction

   // Width that holds the sum of `lanes` signed act_w-bit values of either sign.
   function automatic int unsigned beat_sum_w(input int unsigned act_w, input int unsigned lanes);
      return act_w + $clog2(lanes) + 1;
   endfunction

endpackage

// File: rtl/ternary_channel_mac.sv
// ternary_channel_mac: one output neuron -- ternary lane sum plus a sticky
// accumulator that either clamps or wraps when it leaves the ACC_W range.
module ternary_channel_mac
   import ternary_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int ACT_W    = 8,
   parameter int ACC_W    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    beat,
   input  logic                    clear,
   input  logic [LANES*ACT_W-1:0]  act,
   input  logic [LANES*2-1:0]      wgt,
   output logic signed [ACC_W-1:0] acc,
   output logic                    ovf,
   output logic signed [ACC_W-1:0] acc_next,
   output logic                    ovf_next
);

   localparam int unsigned SUM_W = beat_sum_w(ACT_W, LANES);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACT_W-1:0]        lane_raw;
   logic signed [SUM_W-1:0] lane_val;
   logic signed [SUM_W-1:0] beat_sum;
   logic signed [ACC_W:0]   wide_sum;
   logic                    over;

   // Ternary lane sum: each lane adds its activation, subtracts it, or skips it
   always_comb begin
      beat_sum = '0;
      lane_raw = '0;
      lane_val = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_raw = act[l*ACT_W +: ACT_W];
         lane_val = {{(SUM_W-ACT_W){lane_raw[ACT_W-1]}}, lane_raw};
         case (decode_wgt(wgt[l*2 +: 2]))
            2'sb01:  beat_sum = beat_sum + lane_val;
            2'sb11:  beat_sum = beat_sum - lane_val;
            default: ;
         endcase
      end
   end

   // One extra bit on the add makes overflow visible as a top-two-bit disagreement
   always_comb begin
      wide_sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-SUM_W){beat_sum[SUM_W-1]}}, beat_sum};
      over     = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
      acc_next = wide_sum[ACC_W-1:0];
      if (over && SATURATE) begin
         acc_next = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
      ovf_next = ovf | over;
   end

   // Accumulator and sticky overflow: zeroed when the frame drains, updated per accepted beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (clear) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (beat) begin
         acc <= acc_next;
         ovf <= ovf_next;
      end
   end

endmodule

// File: rtl/ternary_dot_engine.sv
// ternary_dot_engine: CHANNELS parallel ternary dot products over a shared
// activation stream, results serialised one channel per output handshake.
module ternary_dot_engine
   import ternary_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int ACT_W    = 8,
   parameter int CHANNELS = 4,
   parameter int ACC_W    = 16,
   parameter bit SATURATE = 1'b1,
   localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_last,
   input  logic [LANES*ACT_W-1:0]        in_act,
   input  logic [CHANNELS*LANES*2-1:0]   in_wgt,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [ACC_W-1:0]       out_data,
   output logic [CHAN_W-1:0]             out_chan,
   output logic                          out_ovf
);

   localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

   state_t                  state;
   logic                    beat;
   logic                    out_fire;
   logic                    clear;
   logic [CHAN_W-1:0]       chan_inc;
   logic [CHAN_W-1:0]       sel_idx;
   logic signed [ACC_W-1:0] nxt_data;
   logic                    nxt_ovf;
   logic signed [ACC_W-1:0] acc_q [CHANNELS];
   logic signed [ACC_W-1:0] acc_d [CHANNELS];
   logic [CHANNELS-1:0]     ovf_q;
   logic [CHANNELS-1:0]     ovf_d;

   assign in_ready  = rst_n & ena & (state == ST_ACCUM);
   assign out_valid = (state == ST_DRAIN);
   assign beat      = in_valid & in_ready;
   assign out_fire  = ena & out_valid & out_ready;
   assign clear     = out_fire & (out_chan == LAST_CHAN);
   assign chan_inc  = out_chan + CHAN_W'(1);
   assign sel_idx   = (state == ST_DRAIN) ? chan_inc : '0;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      ternary_channel_mac #(
         .LANES    (LANES),
         .ACT_W    (ACT_W),
         .ACC_W    (ACC_W),
         .SATURATE (SATURATE)
      ) u_mac (
         .clk      (clk),
         .rst_n    (rst_n),
         .beat     (beat),
         .clear    (clear),
         .act      (in_act),
         .wgt      (in_wgt[c*LANES*2 +: LANES*2]),
         .acc      (acc_q[c]),
         .ovf      (ovf_q[c]),
         .acc_next (acc_d[c]),
         .ovf_next (ovf_d[c])
      );
   end

   // Next value to present: channel 0's post-beat sum when a frame closes,
   // otherwise the settled result of the channel after the one on the bus
   always_comb begin
      nxt_data = '0;
      nxt_ovf  = 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (CHAN_W'(c) == sel_idx) begin
            nxt_data = (state == ST_ACCUM) ? acc_d[c] : acc_q[c];
            nxt_ovf  = (state == ST_ACCUM) ? ovf_d[c] : ovf_q[c];
         end
      end
   end

   // Frame FSM with registered result bus; nothing moves while ena is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_ACCUM;
         out_chan <= '0;
         out_data <= '0;
         out_ovf  <= 1'b0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (beat && in_last) begin
                  state    <= ST_DRAIN;
                  out_chan <= '0;
                  out_data <= nxt_data;
                  out_ovf  <= nxt_ovf;
               end
            end
            ST_DRAIN: begin
               if (out_fire) begin
                  if (out_chan == LAST_CHAN) begin
                     state    <= ST_ACCUM;
                     out_chan <= '0;
                  end else begin
                     out_chan <= chan_inc;
                     out_data <= nxt_data;
                     out_ovf  <= nxt_ovf;
                  end
               end
            end
            default: state <= ST_ACCUM;
         endcase
      end
   end

endmodule

// File: doc/ternary_dot_engine.md
# ternary_dot_engine

Parametrised streaming ternary dot-product engine, next generation of the single-vector ternary dot block in the TinyTapeout fractal neural-net design. It computes CHANNELS dot products in parallel between one shared signed-activation stream and per-channel ternary weight streams, accumulating across multi-beat frames. It adds saturation/wrap mode selection and an overflow flag. Results are serialised one channel per handshake onto a single ACC_W output port, narrow enough to pack onto the uo_out/uio_out pins.

## Interface
- LANES, 4, activations consumed per beat
- ACT_W, 8, signed activation width
- CHANNELS, 4, parallel output neurons (≥1)
- ACC_W, 16, signed accumulator/result width
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap
- clk  in  1  clock; one clock domain, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low freezes all state
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts beat
- in_last  in  1  final beat of frame
- in_act  in  LANES*ACT_W  signed activations, lane 0 in LSBs
- in_wgt  in  CHANNELS*LANES*2  ternary weights, channel-major, lane-minor, 2 bits each
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W  signed dot-product result
- out_chan  out  clog2(CHANNELS) (min 1)  channel index of out_data
- out_ovf  out  1  overflow occurred in this channel during the frame

## Operation
- Weight encoding: 00 = 0, 01 = +1, 11 = −1, 10 = reserved, decoded as 0.
- Input transfer: in_valid & in_ready & ena. Output transfer: out_valid & out_ready & ena.
- States: ACCUM (reset state), DRAIN.
- ACCUM: in_ready = ena. Each input transfer updates every channel: acc[c] ← acc[c] + Σ_l w(c,l)·act[l].
- Per-beat sum width is ACT_W+clog2(LANES)+1. The addition is done at ACC_W+1 bits.
- Overflow: the result falls outside the signed ACC_W range.
  - SATURATE=1: clamp to +2^(ACC_W−1)−1 or −2^(ACC_W−1).
  - SATURATE=0: keep the low ACC_W bits.
  - Either mode: set ovf[c], which is sticky for the frame.
- Input transfer with in_last: apply the accumulation, then go to DRAIN with chan = 0.
- DRAIN: in_ready = 0; out_valid = 1; out_data = acc[chan]; out_ovf = ovf[chan]; out_chan = chan.
  - Each output transfer increments chan.
  - Transfer of channel CHANNELS−1 clears all acc and ovf and returns to ACCUM.
- Output hold: once out_valid is high, out_data, out_chan and out_ovf are held stable until transfer.
- ena low: no transfers, no state change. in_ready is 0; out_valid and the output data buses hold.
- Single-beat frames (in_last on the first beat) are legal.

## Timing
- Reset values: in_ready = 0 during reset (then follows ena), out_valid = 0, out_data = 0, out_chan = 0, out_ovf = 0, all acc/ovf = 0, state ACCUM.
- Throughput: one input beat per cycle in ACCUM.
- Latency: in_last transfer at edge k → out_valid high from edge k, channel 0 visible in cycle k+1.
- Draining a frame takes a minimum of CHANNELS cycles.
- Frame restart: after the final channel's transfer edge, in_ready rises the next cycle. There is no overlap of DRAIN with input.
- out_valid, out_data, out_chan, out_ovf are registered. in_ready is combinational from state and ena only, never from in_valid.
- Reset asserted mid-frame or mid-drain: all outputs drop to reset values immediately. The partial frame is discarded.

## Structure
- Package ternary_pkg holds:
  - weight code constants (T_ZERO, T_POS, T_NEG, T_RSVD)
  - the decode function
  - the state enum (ST_ACCUM, ST_DRAIN)
  - a function for the per-beat sum width.
- Sub-module ternary_channel_mac, instantiated CHANNELS times. Per channel it contains the ternary lane mux/adder tree plus its acc/ovf registers with saturate/wrap logic.
- The top level holds the FSM, chan counter and output mux/registers.

## Test plan
- Reset/idle: rst_n low with in_valid=1 → out_valid=0, out_data=0, in_ready=0. After release with ena=1, in_ready=1.
- Single-beat frame (defaults), act lanes 0..3 = (10, −3, 5, 127), one beat per case below; outputs channels 0..3 in order with out_ovf=0:
  - ch0 weights (+1,+1,+1,+1) → 139
  - ch1 weights (−1,0,+1,0) → −5
  - ch2 weights (0,−1,0,−1) → −124
  - ch3 weights all code 10 → 0
- Overflow, 300 beats of act all 127 with all weights +1:
  - SATURATE=1 → every channel 32767, out_ovf=1.
  - SATURATE=0 → 21328, out_ovf=1.
  - 100 beats of act all −128, SATURATE=1 → −32768, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles on channel 1 → out_data/out_chan stable, in_ready=0. Release → channels 1..3 follow. in_ready=1 the cycle after the channel 3 transfer. The next frame starts from acc 0.
- ena gating: drop ena for 3 cycles mid-frame with in_valid=1 → no accumulation. Final results equal the same frame run without gaps.
- Reset mid-drain: rst_n low after the channel 1 transfer → out_valid=0 at once. A subsequent single-beat frame yields the fresh values from the single-beat case, not sums including stale accumulator contents.
